// File: rtl/data_mem_controller.sv
// data_mem_controller: round-robin arbiter that multiplexes per-thread
// LSU load/store requests onto the global data memory channels.
module data_mem_controller #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 16,
  parameter int NUM_CHANNELS  = 4,
  parameter int WRITE_ENABLE  = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]            mem_read_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
  input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
  output logic [NUM_CHANNELS-1:0]            mem_write_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
  output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
  input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);

  localparam int   AW = ADDR_BITS;
  localparam int   DW = DATA_BITS;
  localparam int   CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam logic WE = (WRITE_ENABLE != 0);

  typedef enum logic [2:0] {
    IDLE,
    READ_WAITING,
    WRITE_WAITING,
    READ_RELAYING,
    WRITE_RELAYING
  } state_t;

  state_t        state_q [NUM_CHANNELS];
  state_t        state_n [NUM_CHANNELS];
  logic [CW-1:0] owner_q [NUM_CHANNELS];
  logic [CW-1:0] owner_n [NUM_CHANNELS];
  logic [CW-1:0] rr_q    [NUM_CHANNELS];
  logic [CW-1:0] rr_n    [NUM_CHANNELS];

  logic [NUM_CONSUMERS-1:0]    claimed_q;
  logic [NUM_CONSUMERS-1:0]    claimed_n;
  logic [NUM_CONSUMERS-1:0]    taken;
  logic [NUM_CONSUMERS-1:0]    req;
  logic [NUM_CHANNELS-1:0]     mrv_n;
  logic [NUM_CHANNELS-1:0]     mwv_n;
  logic [NUM_CHANNELS*AW-1:0]  mra_n;
  logic [NUM_CHANNELS*AW-1:0]  mwa_n;
  logic [NUM_CHANNELS*DW-1:0]  mwd_n;
  logic [NUM_CONSUMERS-1:0]    crr_n;
  logic [NUM_CONSUMERS-1:0]    cwr_n;
  logic [NUM_CONSUMERS*DW-1:0] crd_n;

  logic          found;
  logic [CW-1:0] pick;
  logic [CW-1:0] cand;
  logic [CW-1:0] own;

  // A write-only request is invisible when writes are disabled
  assign req = consumer_read_valid
             | (consumer_write_valid & {NUM_CONSUMERS{WE}});

  always_comb begin
    state_n   = state_q;
    owner_n   = owner_q;
    rr_n      = rr_q;
    claimed_n = claimed_q;
    taken     = claimed_q;
    mrv_n     = mem_read_valid;
    mra_n     = mem_read_address;
    mwv_n     = mem_write_valid;
    mwa_n     = mem_write_address;
    mwd_n     = mem_write_data;
    crr_n     = consumer_read_ready;
    crd_n     = consumer_read_data;
    cwr_n     = consumer_write_ready;
    found     = 1'b0;
    pick      = '0;
    cand      = '0;
    own       = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      found = 1'b0;
      pick  = '0;
      own   = owner_q[c];
      // taken carries grants of lower channels made this cycle
      for (int k = 0; k < NUM_CONSUMERS; k++) begin
        cand = CW'((int'(rr_q[c]) + k) % NUM_CONSUMERS);
        if (!found && req[cand] && !taken[cand]) begin
          found = 1'b1;
          pick  = cand;
        end
      end
      unique case (state_q[c])
        IDLE: begin
          if (found) begin
            taken[pick]     = 1'b1;
            claimed_n[pick] = 1'b1;
            owner_n[c]      = pick;
            rr_n[c]         = CW'((int'(pick) + 1) % NUM_CONSUMERS);
            if (consumer_read_valid[pick]) begin
              mrv_n[c]            = 1'b1;
              mra_n[c*AW +: AW]   = consumer_read_address[int'(pick)*AW +: AW];
              state_n[c]          = READ_WAITING;
            end else if (WE) begin
              mwv_n[c]            = 1'b1;
              mwa_n[c*AW +: AW]   = consumer_write_address[int'(pick)*AW +: AW];
              mwd_n[c*DW +: DW]   = consumer_write_data[int'(pick)*DW +: DW];
              state_n[c]          = WRITE_WAITING;
            end
          end
        end
        READ_WAITING: begin
          if (mem_read_ready[c]) begin
            crd_n[int'(own)*DW +: DW] = mem_read_data[c*DW +: DW];
            crr_n[own]                = 1'b1;
            mrv_n[c]                  = 1'b0;
            state_n[c]                = READ_RELAYING;
          end
        end
        WRITE_WAITING: begin
          if (mem_write_ready[c]) begin
            cwr_n[own] = 1'b1;
            mwv_n[c]   = 1'b0;
            state_n[c] = WRITE_RELAYING;
          end
        end
        READ_RELAYING: begin
          if (!consumer_read_valid[own]) begin
            crr_n[own]     = 1'b0;
            claimed_n[own] = 1'b0;
            state_n[c]     = IDLE;
          end
        end
        WRITE_RELAYING: begin
          if (!consumer_write_valid[own]) begin
            cwr_n[own]     = 1'b0;
            claimed_n[own] = 1'b0;
            state_n[c]     = IDLE;
          end
        end
        default: state_n[c] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        state_q[c] <= IDLE;
        owner_q[c] <= '0;
        rr_q[c]    <= '0;
      end
      claimed_q            <= '0;
      mem_read_valid       <= '0;
      mem_read_address     <= '0;
      mem_write_valid      <= '0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
      consumer_read_ready  <= '0;
      consumer_read_data   <= '0;
      consumer_write_ready <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        state_q[c] <= state_n[c];
        owner_q[c] <= owner_n[c];
        rr_q[c]    <= rr_n[c];
      end
      claimed_q            <= claimed_n;
      mem_read_valid       <= mrv_n;
      mem_read_address     <= mra_n;
      mem_write_valid      <= mwv_n;
      mem_write_address    <= mwa_n;
      mem_write_data       <= mwd_n;
      consumer_read_ready  <= crr_n;
      consumer_read_data   <= crd_n;
      consumer_write_ready <= cwr_n;
    end
  end

endmodule

// File: tb/tb_data_mem_controller.sv
// tb_data_mem_controller: scoreboard bench with a behavioural memory
// and per-consumer expected-response queues.
module tb_data_mem_controller;
  localparam int A   = 8;
  localparam int D   = 8;
  localparam int NC  = 16;
  localparam int NCH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NC-1:0]    consumer_read_valid;
  logic [NC*A-1:0]  consumer_read_address;
  logic [NC-1:0]    consumer_read_ready;
  logic [NC*D-1:0]  consumer_read_data;
  logic [NC-1:0]    consumer_write_valid;
  logic [NC*A-1:0]  consumer_write_address;
  logic [NC*D-1:0]  consumer_write_data;
  logic [NC-1:0]    consumer_write_ready;
  logic [NCH-1:0]   mem_read_valid;
  logic [NCH*A-1:0] mem_read_address;
  logic [NCH-1:0]   mem_read_ready;
  logic [NCH*D-1:0] mem_read_data;
  logic [NCH-1:0]   mem_write_valid;
  logic [NCH*A-1:0] mem_write_address;
  logic [NCH*D-1:0] mem_write_data;
  logic [NCH-1:0]   mem_write_ready;

  data_mem_controller #(
    .ADDR_BITS(A), .DATA_BITS(D), .NUM_CONSUMERS(NC),
    .NUM_CHANNELS(NCH), .WRITE_ENABLE(1)
  ) dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(consumer_read_valid),
    .consumer_read_address(consumer_read_address),
    .consumer_read_ready(consumer_read_ready),
    .consumer_read_data(consumer_read_data),
    .consumer_write_valid(consumer_write_valid),
    .consumer_write_address(consumer_write_address),
    .consumer_write_data(consumer_write_data),
    .consumer_write_ready(consumer_write_ready),
    .mem_read_valid(mem_read_valid),
    .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready),
    .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid),
    .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data),
    .mem_write_ready(mem_write_ready)
  );

  // Read-only variant: 4 consumers on 2 channels
  logic [3:0]  ro_rv, ro_rr, ro_wv, ro_wr;
  logic [31:0] ro_ra, ro_rd, ro_wa, ro_wd;
  logic [1:0]  ro_mrv, ro_mrr, ro_mwv, ro_mwr;
  logic [15:0] ro_mra, ro_mrd, ro_mwa, ro_mwd;

  data_mem_controller #(
    .ADDR_BITS(A), .DATA_BITS(D), .NUM_CONSUMERS(4),
    .NUM_CHANNELS(2), .WRITE_ENABLE(0)
  ) dut_ro (
    .clk(clk), .reset(reset),
    .consumer_read_valid(ro_rv),
    .consumer_read_address(ro_ra),
    .consumer_read_ready(ro_rr),
    .consumer_read_data(ro_rd),
    .consumer_write_valid(ro_wv),
    .consumer_write_address(ro_wa),
    .consumer_write_data(ro_wd),
    .consumer_write_ready(ro_wr),
    .mem_read_valid(ro_mrv),
    .mem_read_address(ro_mra),
    .mem_read_ready(ro_mrr),
    .mem_read_data(ro_mrd),
    .mem_write_valid(ro_mwv),
    .mem_write_address(ro_mwa),
    .mem_write_data(ro_mwd),
    .mem_write_ready(ro_mwr)
  );

  logic       rv [NC];
  logic       wv [NC];
  logic [7:0] ra [NC];
  logic [7:0] wa [NC];
  logic [7:0] wd [NC];

  for (genvar i = 0; i < NC; i++) begin : g_pack
    assign consumer_read_valid[i]          = rv[i];
    assign consumer_write_valid[i]         = wv[i];
    assign consumer_read_address[i*A +: A] = ra[i];
    assign consumer_write_address[i*A +: A] = wa[i];
    assign consumer_write_data[i*D +: D]   = wd[i];
  end

  typedef struct {
    bit         rd;
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q [NC][$];
  exp_t       mon_e;
  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];
  int         served  [NC];
  int         rcnt    [NCH];
  logic [7:0] radr    [NCH];
  logic [7:0] a_cur;
  logic [NC-1:0] prev_rr, prev_wr;
  int lat_min = 1;
  int lat_max = 1;
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_mem(input logic [7:0] a, input logic [7:0] d);
    mem[a]     = d;
    ref_mem[a] = d;
  endtask

  task automatic push_exp(input int i, input bit rd,
                          input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    e.rd   = rd;
    e.addr = a;
    e.data = d;
    exp_q[i].push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < NC; i++) begin
      rv[i] = 1'b0;
      wv[i] = 1'b0;
      exp_q[i].delete();
      served[i] = 0;
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_ready(input int i, input bit rd, output int n);
    bit seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 400) begin
      @(negedge clk);
      n++;
      seen = rd ? consumer_read_ready[i] : consumer_write_ready[i];
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL timeout c%0d rd=%0d: got no ready, want ready", i, rd);
    end
  endtask

  task automatic run_consumer(input int i, input int count);
    int kind, n;
    logic [7:0] ar, aw, dw;
    for (int t = 0; t < count; t++) begin
      kind = int'($urandom_range(0, 2));
      ar   = 8'(i * 16 + int'($urandom_range(0, 15)));
      aw   = 8'(i * 16 + int'($urandom_range(0, 15)));
      dw   = 8'($urandom);
      @(negedge clk);
      if (kind != 1) begin
        ra[i] = ar;
        rv[i] = 1'b1;
        push_exp(i, 1'b1, ar, ref_mem[ar]);
      end
      if (kind != 0) begin
        wa[i] = aw;
        wd[i] = dw;
        wv[i] = 1'b1;
        push_exp(i, 1'b0, aw, dw);
        ref_mem[aw] = dw;
      end
      if (kind != 1) begin
        wait_ready(i, 1'b1, n);
        rv[i] = 1'b0;
      end
      if (kind != 0) begin
        wait_ready(i, 1'b0, n);
        wv[i] = 1'b0;
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic any_w, got;
    reset           = 1'b1;
    mem_read_ready  = '0;
    mem_write_ready = '0;
    mem_read_data   = '0;
    ro_rv = '0; ro_wv = '0; ro_ra = '0; ro_wa = '0; ro_wd = '0;
    ro_mrr = '0; ro_mwr = '0; ro_mrd = '0;
    prev_rr = '0;
    prev_wr = '0;
    for (int i = 0; i < NC; i++) begin
      rv[i] = 1'b0; wv[i] = 1'b0;
      ra[i] = '0;   wa[i] = '0;  wd[i] = '0;
      served[i] = 0;
    end
    for (int a = 0; a < 256; a++) set_mem(8'(a), 8'(a) ^ 8'h5A);
    for (int c = 0; c < NCH; c++) rcnt[c] = -1;

    fork
      // memory model: one ready pulse per request after a random latency
      forever begin
        @(negedge clk);
        for (int c = 0; c < NCH; c++) begin
          mem_read_ready[c]  = 1'b0;
          mem_write_ready[c] = 1'b0;
          if (reset || !(mem_read_valid[c] || mem_write_valid[c])) begin
            rcnt[c] = -1;
          end else begin
            a_cur = mem_read_valid[c] ? mem_read_address[c*A +: A]
                                      : mem_write_address[c*A +: A];
            if (rcnt[c] == -1) begin
              rcnt[c] = int'($urandom_range(lat_min, lat_max));
              radr[c] = a_cur;
            end
            if (rcnt[c] == 0) begin
              check("mem_addr_stable", 32'(a_cur), 32'(radr[c]));
              if (mem_read_valid[c]) begin
                mem_read_data[c*D +: D] = mem[a_cur];
                mem_read_ready[c] = 1'b1;
              end else begin
                mem[a_cur] = mem_write_data[c*D +: D];
                mem_write_ready[c] = 1'b1;
              end
              rcnt[c] = -2;
            end else if (rcnt[c] > 0) begin
              rcnt[c]--;
            end
          end
        end
      end
      // monitor: pops the scoreboard on each consumer ready rise
      forever begin
        @(negedge clk);
        for (int i = 0; i < NC; i++) begin
          if (consumer_read_ready[i] && !prev_rr[i]) begin
            served[i]++;
            if (exp_q[i].size() == 0 || !exp_q[i][0].rd) begin
              checks++; errors++;
              $display("FAIL unexpected_read_ready c%0d: got ready, want none", i);
            end else begin
              mon_e = exp_q[i].pop_front();
              check($sformatf("read_data c%0d", i),
                    32'(consumer_read_data[i*D +: D]), 32'(mon_e.data));
            end
          end
          if (consumer_write_ready[i] && !prev_wr[i]) begin
            served[i]++;
            if (exp_q[i].size() == 0 || exp_q[i][0].rd) begin
              checks++; errors++;
              $display("FAIL unexpected_write_ready c%0d: got ready, want none", i);
            end else begin
              mon_e = exp_q[i].pop_front();
              check($sformatf("write_mem c%0d", i),
                    32'(mem[mon_e.addr]), 32'(mon_e.data));
            end
          end
        end
        prev_rr = consumer_read_ready;
        prev_wr = consumer_write_ready;
      end
    join_none

    repeat (2) @(negedge clk);
    check("reset_outputs", 32'(|{mem_read_valid, mem_read_address,
          mem_write_valid, mem_write_address, mem_write_data,
          consumer_read_ready, consumer_read_data, consumer_write_ready}), 0);
    reset = 1'b0;

    // single read, memory ready one cycle after valid
    do_reset();
    lat_min = 1; lat_max = 1;
    set_mem(8'd5, 8'd2);
    ra[3] = 8'd5; rv[3] = 1'b1;
    push_exp(3, 1'b1, 8'd5, 8'd2);
    @(negedge clk);
    check("single_mvalid", 32'(mem_read_valid), 32'h1);
    check("single_maddr", 32'(mem_read_address[7:0]), 32'd5);
    @(negedge clk);
    check("single_ready_early", 32'(consumer_read_ready), 32'h0);
    @(negedge clk);
    check("single_ready_t3", 32'(consumer_read_ready), 32'h0008);
    rv[3] = 1'b0;
    @(negedge clk);
    check("single_ready_drop", 32'(consumer_read_ready), 32'h0);
    check("single_data_hold", 32'(consumer_read_data[31:24]), 32'd2);
    ra[5] = 8'h55; rv[5] = 1'b1;
    push_exp(5, 1'b1, 8'h55, ref_mem[8'h55]);
    @(negedge clk);
    check("regrant_mvalid", 32'(mem_read_valid), 32'h1);
    check("regrant_maddr", 32'(mem_read_address[7:0]), 32'h55);
    wait_ready(5, 1'b1, n);
    rv[5] = 1'b0;

    // four simultaneous reads spread over four channels
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_mem(8'(i), 8'(i + 1));
      ra[i] = 8'(i); rv[i] = 1'b1;
      push_exp(i, 1'b1, 8'(i), 8'(i + 1));
    end
    @(negedge clk);
    check("quad_mvalid", 32'(mem_read_valid), 32'hF);
    check("quad_maddr", mem_read_address, 32'h03020100);
    for (int i = 0; i < 4; i++) begin
      wait_ready(i, 1'b1, n);
      rv[i] = 1'b0;
    end

    // read and write together: read first, then the write
    do_reset();
    ra[7] = 8'd4; wa[7] = 8'd8; wd[7] = 8'd7;
    rv[7] = 1'b1; wv[7] = 1'b1;
    push_exp(7, 1'b1, 8'd4, ref_mem[8'd4]);
    push_exp(7, 1'b0, 8'd8, 8'd7);
    ref_mem[8] = 8'd7;
    @(negedge clk);
    check("rw_read_first", 32'({mem_write_valid, mem_read_valid}), 32'h01);
    wait_ready(7, 1'b1, n);
    rv[7] = 1'b0;
    wait_ready(7, 1'b0, n);
    check("rw_mem8", 32'(mem[8]), 32'd7);
    wv[7] = 1'b0;

    // async reset in the middle of a read
    do_reset();
    lat_min = 5; lat_max = 5;
    ra[0] = 8'h0A; rv[0] = 1'b1;
    ra[1] = 8'h1B; rv[1] = 1'b1;
    @(negedge clk);
    check("pre_reset_mvalid", 32'(mem_read_valid), 32'h3);
    #2 reset = 1'b1;
    #1;
    check("async_reset_outputs", 32'(|{mem_read_valid, mem_read_address,
          mem_write_valid, mem_write_address, mem_write_data,
          consumer_read_ready, consumer_read_data, consumer_write_ready}), 0);
    rv[0] = 1'b0; rv[1] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    lat_min = 1; lat_max = 1;
    ra[0] = 8'h0C; rv[0] = 1'b1;
    ra[2] = 8'h2C; rv[2] = 1'b1;
    push_exp(0, 1'b1, 8'h0C, ref_mem[8'h0C]);
    push_exp(2, 1'b1, 8'h2C, ref_mem[8'h2C]);
    @(negedge clk);
    check("post_reset_maddr", 32'(mem_read_address[15:0]), 32'h2C0C);
    wait_ready(0, 1'b1, n);
    rv[0] = 1'b0;
    wait_ready(2, 1'b1, n);
    rv[2] = 1'b0;

    // matmul-style: 16 held reads, fixed 2-cycle memory latency
    do_reset();
    lat_min = 2; lat_max = 2;
    for (int i = 0; i < NC; i++) begin
      ra[i] = 8'(i * 16 + 1); rv[i] = 1'b1;
      push_exp(i, 1'b1, ra[i], ref_mem[ra[i]]);
    end
    fork
      begin
        for (int i = 0; i < NC; i++) begin
          automatic int k = i;
          fork
            begin
              int m;
              wait_ready(k, 1'b1, m);
              rv[k] = 1'b0;
              check($sformatf("matmul_round c%0d", k), 32'(m), 32'(4 + 5 * (k / 4)));
            end
          join_none
        end
        wait fork;
      end
    join
    @(negedge clk);
    for (int i = 0; i < NC; i++)
      check($sformatf("matmul_once c%0d", i), 32'(served[i]), 32'd1);

    // randomized traffic over private address regions
    do_reset();
    lat_min = 0; lat_max = 3;
    fork
      begin
        for (int i = 0; i < NC; i++) begin
          automatic int k = i;
          fork
            run_consumer(k, 10);
          join_none
        end
        wait fork;
      end
    join
    repeat (2) @(negedge clk);
    for (int i = 0; i < NC; i++)
      check($sformatf("drained c%0d", i), 32'(exp_q[i].size()), 0);

    // read-only controller: write-only request ignored, read served
    do_reset();
    any_w = 1'b0;
    got   = 1'b0;
    ro_wv = 4'b0100; ro_wa = 32'h00220000; ro_wd = 32'h00990000;
    repeat (8) begin
      @(negedge clk);
      any_w |= (|{ro_mwv, ro_mwa, ro_mwd}) | ro_wr[2];
    end
    ro_rv = 4'b0100; ro_ra = 32'h00210000;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      any_w |= (|{ro_mwv, ro_mwa, ro_mwd}) | ro_wr[2];
      ro_mrr = ro_mrv;
      ro_mrd = 16'h3C3C;
      got = ro_rr[2];
    end
    check("ro_read_ready", 32'(got), 32'd1);
    check("ro_read_data", 32'(ro_rd[23:16]), 32'h3C);
    check("ro_no_write", 32'(any_w), 32'd0);
    ro_rv = '0; ro_wv = '0; ro_mrr = '0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
